pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 16, 32 and 64.
REQ-002 SHALL have parameter OPW, default 16, giving the one-hot opcode width; the value is fixed at 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of in-flight and held work.
REQ-006 SHALL have port in_valid, input, 1 bit: request valid.
REQ-007 SHALL have port in_ready, output, 1 bit: request accepted this cycle when in_valid and in_ready are both high.
REQ-008 SHALL have port alu_op, input, OPW bits, one-hot, with this bit mapping:
- 0 add; 1 pass src1; 2 or; 3 sub; 4 xor; 5 sra; 6 and; 7 sll
- 8 srl; 9 sltu; 10 nor; 11 slt; 12 mul-low; 13 mulh-signed; 14 div-signed; 15 mod-signed
REQ-009 SHALL have port alu_src1, input, XLEN bits: operand A.
REQ-010 SHALL have port alu_src2, input, XLEN bits: operand B.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result when out_valid and out_ready are both high.
REQ-013 SHALL have port alu_result, output, XLEN bits: the result.
REQ-014 SHALL have port out_dz, output, 1 bit: the result came from a division or modulo by zero.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, DIV and HOLD.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready), with flush low.
REQ-017 SHALL complete ops 0-13 with 1-cycle latency: accepted at edge N, out_valid high after edge N, state goes to HOLD.
REQ-018 SHALL compute add/sub as an XLEN-bit modulo result.
REQ-019 SHALL take the shift amount for sll/srl/sra from alu_src2[log2(XLEN)-1:0].
REQ-020 SHALL compute slt as a signed compare and sltu as an unsigned compare, giving 1 or 0 zero-extended.
REQ-021 SHALL compute mul-low as the low XLEN bits of A*B, and mulh as the high XLEN bits of the signed 2*XLEN-bit product.
REQ-022 SHALL execute div/mod with a radix-2 restoring divider on operand magnitudes, applying signs at the end:
- accept, then XLEN DIV cycles, then HOLD
- out_valid rises exactly XLEN+1 edges after acceptance
REQ-023 SHALL give quotient = all-ones and remainder = A on divide-by-zero, with out_dz=1; the divider is not run (1-cycle latency).
REQ-024 SHALL give quotient = A and remainder = 0 for A = most-negative and B = -1, with out_dz=0.
REQ-025 SHALL keep in_ready=0 during DIV and SHALL NOT accept a new request.
REQ-026 SHALL hold alu_result and out_dz stable in HOLD while out_ready=0.
REQ-027 SHALL, in HOLD, handle handshakes as follows:
- out_ready=1 and in_valid=1 with a 1-cycle op: accept back-to-back, giving one result per cycle
- out_ready=1 with no new request: go to IDLE
REQ-028 SHALL, when flush=1 in any state, go to IDLE next edge, clear out_valid, abort the divider, and ignore same-cycle in_valid (in_ready=0 while flush=1).
REQ-029 SHALL treat a zero or multi-hot alu_op as undefined, with no state corruption beyond a single result.

Reset
REQ-030 SHALL, on resetn=0, asynchronously force: state=IDLE, out_valid=0, alu_result=0, out_dz=0, divider counter=0.
REQ-031 SHALL give in_ready=1 in the first cycle after resetn deasserts.
REQ-032 SHALL, on reset during DIV, discard the partial result and produce no output.

Configuration
REQ-033 SHALL support macro PIPE_ALU_DIV_EN:
- defined: behaviour per REQ-022..REQ-024
- undefined: no divider logic and no DIV state; ops 14/15 complete in 1 cycle with alu_result=0 and out_dz=1

Verification
REQ-034 SHALL pass: XLEN=32, add 0xFFFFFFFF+1 then sub 0-1 back-to-back with out_ready=1 -> results 0x00000000, 0xFFFFFFFF on consecutive cycles.
REQ-035 SHALL pass: XLEN=32, sra 0x80000000 by src2=0x21 -> 0xC0000000 (amount 1); slt -1<1 -> 1; sltu -1<1 -> 0.
REQ-036 SHALL pass: div -7/2 -> 0xFFFFFFFD after 33 edges, in_ready=0 throughout; mod -7%2 -> 0xFFFFFFFF.
REQ-037 SHALL pass: div 5/0 -> 0xFFFFFFFF with out_dz=1 at 1-cycle latency; div 0x80000000/-1 -> 0x80000000.
REQ-038 SHALL pass: mulh 0x80000000*0x80000000 -> 0x40000000; hold out_ready=0 for 5 cycles -> output stable and in_ready=0.
REQ-039 SHALL pass: flush at DIV cycle 10 -> IDLE next edge, no out_valid, next add accepted; repeat with resetn pulse mid-DIV -> same.

Source files
------------

// File: rtl/pipe_alu.sv
// Pipelined single-issue ALU: one-cycle ops plus an optional radix-2 restoring divider.
// Define PIPE_ALU_DIV_EN to build the divider (DIV state); otherwise div/mod report out_dz.
module pipe_alu #(
  parameter int XLEN = 32,
  parameter int OPW  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            out_dz
);

  localparam int SHW = $clog2(XLEN);

`ifdef PIPE_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  state_t            state, next_state;
  logic              accept;
  logic [3:0]        op_idx;
  logic              op_hit;
  logic [SHW-1:0]    shamt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   imm_result;
  logic              imm_dz;
  logic              start_div;

  assign in_ready  = !flush && (state == IDLE || (state == HOLD && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign shamt     = alu_src2[SHW-1:0];
  assign prod      = {{XLEN{alu_src1[XLEN-1]}}, alu_src1} * {{XLEN{alu_src2[XLEN-1]}}, alu_src2};

  // Lowest set opcode bit wins, so a multi-hot opcode still yields exactly one result.
  always_comb begin
    op_idx = 4'd0;
    op_hit = 1'b0;
    for (int i = OPW - 1; i >= 0; i--) begin
      if (alu_op[i]) begin
        op_idx = i[3:0];
        op_hit = 1'b1;
      end
    end
  end

  always_comb begin
    imm_result = '0;
    imm_dz     = 1'b0;
    start_div  = 1'b0;
    if (op_hit) begin
      case (op_idx)
        4'd0:  imm_result = alu_src1 + alu_src2;
        4'd1:  imm_result = alu_src1;
        4'd2:  imm_result = alu_src1 | alu_src2;
        4'd3:  imm_result = alu_src1 - alu_src2;
        4'd4:  imm_result = alu_src1 ^ alu_src2;
        4'd5:  imm_result = $unsigned($signed(alu_src1) >>> shamt);
        4'd6:  imm_result = alu_src1 & alu_src2;
        4'd7:  imm_result = alu_src1 << shamt;
        4'd8:  imm_result = alu_src1 >> shamt;
        4'd9:  imm_result = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
        4'd10: imm_result = ~(alu_src1 | alu_src2);
        4'd11: imm_result = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
        4'd12: imm_result = prod[XLEN-1:0];
        4'd13: imm_result = prod[2*XLEN-1:XLEN];
        default: begin
`ifdef PIPE_ALU_DIV_EN
          if (alu_src2 == '0) begin
            imm_result = (op_idx == 4'd14) ? '1 : alu_src1;
            imm_dz     = 1'b1;
          end else begin
            start_div  = 1'b1;
          end
`else
          imm_dz = 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef PIPE_ALU_DIV_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] rem, quo, dvs;
  logic            neg_q, neg_r, is_mod;
  logic [XLEN:0]   rem_sh, diff;
  logic            step_ge;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_mag   = alu_src1[XLEN-1] ? -alu_src1 : alu_src1;
  assign b_mag   = alu_src2[XLEN-1] ? -alu_src2 : alu_src2;
  // One restoring step: shift the next dividend bit in and keep the trial difference if it did not borrow.
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign step_ge = !diff[XLEN];
  assign rem_nx  = step_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], step_ge};
  assign q_fin   = neg_q ? -quo_nx : quo_nx;
  assign r_fin   = neg_r ? -rem_nx : rem_nx;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = start_div ? DIV_OR_HOLD() : HOLD;
`ifdef PIPE_ALU_DIV_EN
      DIV:  if (cnt == CNT_LAST) next_state = HOLD;
`endif
      HOLD: if (out_ready) next_state = accept ? (start_div ? DIV_OR_HOLD() : HOLD) : IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  function automatic state_t DIV_OR_HOLD();
`ifdef PIPE_ALU_DIV_EN
    return DIV;
`else
    return HOLD;
`endif
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_result <= '0;
      out_dz     <= 1'b0;
`ifdef PIPE_ALU_DIV_EN
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_mod <= 1'b0;
`endif
    end else if (flush) begin
`ifdef PIPE_ALU_DIV_EN
      cnt <= '0;
`endif
    end else if (accept) begin
      if (!start_div) begin
        alu_result <= imm_result;
        out_dz     <= imm_dz;
      end
`ifdef PIPE_ALU_DIV_EN
      else begin
        cnt    <= '0;
        rem    <= '0;
        quo    <= a_mag;
        dvs    <= b_mag;
        neg_q  <= alu_src1[XLEN-1] ^ alu_src2[XLEN-1];
        neg_r  <= alu_src1[XLEN-1];
        is_mod <= (op_idx == 4'd15);
      end
`endif
    end
`ifdef PIPE_ALU_DIV_EN
    else if (state == DIV) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        alu_result <= is_mod ? r_fin : q_fin;
        out_dz     <= 1'b0;
        cnt        <= '0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu (XLEN=32): directed corner cases plus randomized ops
// checked against a longint arithmetic reference; adapts to PIPE_ALU_DIV_EN.
module tb_pipe_alu;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     alu_op;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            out_dz;

  int checks = 0;
  int errors = 0;

  pipe_alu #(.XLEN(XLEN), .OPW(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference computed from the operation definitions with 64-bit signed arithmetic.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz, output int lat);
    longint sa, sb, p;
    int sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b[4:0]);
    p   = sa * sb;
    dz  = 1'b0;
    lat = 1;
    case (op)
      0:  r = a + b;
      1:  r = a;
      2:  r = a | b;
      3:  r = a - b;
      4:  r = a ^ b;
      5:  r = 32'(sa >>> sh);
      6:  r = a & b;
      7:  r = a << sh;
      8:  r = a >> sh;
      9:  r = (a < b) ? 32'd1 : 32'd0;
      10: r = ~(a | b);
      11: r = (sa < sb) ? 32'd1 : 32'd0;
      12: r = p[31:0];
      13: r = p[63:32];
      default: begin
`ifdef PIPE_ALU_DIV_EN
        if (b == 32'd0) begin
          r  = (op == 14) ? 32'hFFFF_FFFF : a;
          dz = 1'b1;
        end else begin
          r   = (op == 14) ? 32'(sa / sb) : 32'(sa % sb);
          lat = XLEN + 1;
        end
`else
        r  = 32'd0;
        dz = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic apply_stimulus(input int op, input logic [31:0] a, input logic [31:0] b);
    alu_op     = '0;
    alu_op[op] = 1'b1;
    alu_src1   = a;
    alu_src2   = b;
    in_valid   = 1'b1;
  endtask

  // Issues one op from IDLE, checks latency, result, stall stability and return to IDLE.
  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output logic [31:0] res);
    logic [31:0] exp_r;
    logic        exp_dz;
    int          exp_lat, lat, n;
    logic        busy_ready;
    model(op, a, b, exp_r, exp_dz, exp_lat);
    apply_stimulus(op, a, b);
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_output({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check_output({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check_output({tag, "_busy_ready"}, 64'(busy_ready), 64'd0);
    check_output({tag, "_result"}, 64'(alu_result), 64'(exp_r));
    check_output({tag, "_dz"}, 64'(out_dz), 64'(exp_dz));
    res = alu_result;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_output({tag, "_stall"}, {30'd0, out_valid, in_ready, alu_result, out_dz},
                   {30'd0, 1'b1, 1'b0, exp_r, exp_dz});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output({tag, "_to_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic        seen;
    int          op, stall;
    logic [31:0] a, b;

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = '0;
    alu_src1  = '0;
    alu_src2  = '0;
    #12;
    check_output("reset_state", {31'd0, out_valid, alu_result, out_dz}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_output("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back add then sub with the consumer always ready.
    apply_stimulus(0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    check_output("b2b_add", {30'd0, out_valid, in_ready, alu_result}, {30'd0, 1'b1, 1'b1, 32'h0000_0000});
    apply_stimulus(3, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("b2b_sub", {31'd0, out_valid, alu_result}, {31'd0, 1'b1, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    check_output("b2b_idle", 64'(out_valid), 64'd0);

    run_op("sra", 5, 32'h8000_0000, 32'h21, 0, res);
    check_output("sra_const", 64'(res), 64'hC000_0000);
    run_op("slt", 11, 32'hFFFF_FFFF, 32'd1, 0, res);
    check_output("slt_const", 64'(res), 64'd1);
    run_op("sltu", 9, 32'hFFFF_FFFF, 32'd1, 0, res);
    check_output("sltu_const", 64'(res), 64'd0);
    run_op("mulh", 13, 32'h8000_0000, 32'h8000_0000, 5, res);
    check_output("mulh_const", 64'(res), 64'h4000_0000);

    run_op("div_neg", 14, 32'hFFFF_FFF9, 32'd2, 0, res);
    run_op("mod_neg", 15, 32'hFFFF_FFF9, 32'd2, 0, res);
    run_op("div_zero", 14, 32'd5, 32'd0, 0, res);
    run_op("mod_zero", 15, 32'd5, 32'd0, 2, res);
    run_op("div_ovf", 14, 32'h8000_0000, 32'hFFFF_FFFF, 0, res);
    run_op("mod_ovf", 15, 32'h8000_0000, 32'hFFFF_FFFF, 0, res);
`ifdef PIPE_ALU_DIV_EN
    check_output("div_neg_const", 64'(res), 64'd0);
`endif

    // Flush while a result is held.
    apply_stimulus(0, 32'd3, 32'd4);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("hold_before_flush", {31'd0, out_valid, alu_result}, {31'd0, 1'b1, 32'd7});
    flush = 1'b1;
    #1;
    check_output("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    check_output("flush_hold_cleared", 64'(out_valid), 64'd0);

`ifdef PIPE_ALU_DIV_EN
    // Flush on the tenth divider cycle, with a competing request in the same cycle.
    apply_stimulus(14, 32'd100, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    apply_stimulus(0, 32'd1, 32'd1);
    #1;
    check_output("div_flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_output("div_flush_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check_output("div_flush_no_output", 64'(seen), 64'd0);
    run_op("after_flush_add", 0, 32'd10, 32'd20, 0, res);

    // Reset pulse in the middle of a division.
    apply_stimulus(15, 32'd1000, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    check_output("div_reset_state", {31'd0, out_valid, alu_result, out_dz}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check_output("div_reset_no_output", 64'(seen), 64'd0);
    check_output("div_reset_in_ready", 64'(in_ready), 64'd1);
    run_op("after_reset_add", 0, 32'd7, 32'd8, 0, res);
`endif

    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      stall = int'($urandom_range(0, 2));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, stall, res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
